// File: rtl/id_exe_pkg.sv
// Shared constants and slot types for the ID/EXE pipeline register.
// Also holds the priority decode of the ctrl inputs.
package id_exe_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int ADDR_WIDTH     = 32;
    localparam int RADDR_WIDTH    = 5;
    localparam int CSR_ADDR_WIDTH = 12;

    localparam logic [DATA_WIDTH-1:0]  NOP           = 32'h0000_0013;
    localparam logic [6:0]             INST_TYPE_L   = 7'b0000011;
    localparam logic [DATA_WIDTH-1:0]  ZERO          = '0;
    localparam logic [RADDR_WIDTH-1:0] ZERO_REG      = '0;
    localparam logic                   WRITE_ENABLE  = 1'b1;
    localparam logic                   WRITE_DISABLE = 1'b0;

    typedef enum logic [1:0] {
        ACT_LOAD,
        ACT_BUBBLE,
        ACT_HOLD,
        ACT_FLUSH
    } action_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     inst;
        logic [ADDR_WIDTH-1:0]     inst_addr;
        logic [DATA_WIDTH-1:0]     op1;
        logic [DATA_WIDTH-1:0]     op2;
        logic                      reg_we;
        logic [RADDR_WIDTH-1:0]    reg_waddr;
        logic                      csr_we;
        logic [CSR_ADDR_WIDTH-1:0] csr_addr;
        logic [DATA_WIDTH-1:0]     exception;
        logic                      valid;
        logic                      is_load;
        logic [RADDR_WIDTH-1:0]    rd;
    } slot_t;

    function automatic slot_t bubble_slot();
        slot_t s;
        s.inst      = NOP;
        s.inst_addr = ZERO;
        s.op1       = ZERO;
        s.op2       = ZERO;
        s.reg_we    = WRITE_DISABLE;
        s.reg_waddr = ZERO_REG;
        s.csr_we    = WRITE_DISABLE;
        s.csr_addr  = '0;
        s.exception = ZERO;
        s.valid     = 1'b0;
        s.is_load   = 1'b0;
        s.rd        = ZERO_REG;
        return s;
    endfunction

    // Flush beats hold beats decode-stall; otherwise the slot is loaded.
    function automatic action_e decode_action(input logic flush, input logic stall_exe,
                                              input logic stall_id);
        if (flush)          return ACT_FLUSH;
        else if (stall_exe) return ACT_HOLD;
        else if (stall_id)  return ACT_BUBBLE;
        else                return ACT_LOAD;
    endfunction

endpackage

// File: rtl/id_exe_sat_cnt16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_cnt16
    import id_exe_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        inc_i,
    output logic [15:0] cnt_o
);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != 16'hFFFF)) begin
            cnt_o <= cnt_o + 16'd1;
        end
    end

endmodule

// File: rtl/id_exe.sv
// ID/EXE pipeline register: loads, holds or squashes the execute slot and
// exports load-use hazard info plus bubble/flush statistics.
module id_exe
    import id_exe_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [DATA_WIDTH-1:0]     inst_i,
    input  logic [ADDR_WIDTH-1:0]     inst_addr_i,
    input  logic [DATA_WIDTH-1:0]     op1_i,
    input  logic [DATA_WIDTH-1:0]     op2_i,
    input  logic                      reg_we_i,
    input  logic [RADDR_WIDTH-1:0]    reg_waddr_i,
    input  logic                      csr_we_i,
    input  logic [CSR_ADDR_WIDTH-1:0] csr_addr_i,
    input  logic [DATA_WIDTH-1:0]     exception_i,
    input  logic                      flush_i,
    input  logic                      stall_exe_i,
    input  logic                      stall_id_i,
    output logic [DATA_WIDTH-1:0]     inst_o,
    output logic [ADDR_WIDTH-1:0]     inst_addr_o,
    output logic [DATA_WIDTH-1:0]     op1_o,
    output logic [DATA_WIDTH-1:0]     op2_o,
    output logic                      reg_we_o,
    output logic [RADDR_WIDTH-1:0]    reg_waddr_o,
    output logic                      csr_we_o,
    output logic [CSR_ADDR_WIDTH-1:0] csr_addr_o,
    output logic [DATA_WIDTH-1:0]     exception_o,
    output logic                      valid_o,
    output logic                      pre_inst_is_load_o,
    output logic [RADDR_WIDTH-1:0]    exe_rd_o,
    output logic [15:0]               bubble_cnt_o,
    output logic [15:0]               flush_cnt_o
);

    action_e action_p0;
    slot_t   slot_d_p0;
    slot_t   slot_p1;

    assign action_p0 = decode_action(flush_i, stall_exe_i, stall_id_i);

    // Stage p0: choose next slot contents from the decode side
    always_comb begin
        slot_d_p0 = slot_p1;
        case (action_p0)
            ACT_FLUSH, ACT_BUBBLE: slot_d_p0 = bubble_slot();
            ACT_HOLD:              slot_d_p0 = slot_p1;
            ACT_LOAD: begin
                slot_d_p0.inst      = inst_i;
                slot_d_p0.inst_addr = inst_addr_i;
                slot_d_p0.op1       = op1_i;
                slot_d_p0.op2       = op2_i;
                slot_d_p0.reg_we    = reg_we_i;
                slot_d_p0.reg_waddr = reg_waddr_i;
                slot_d_p0.csr_we    = csr_we_i;
                slot_d_p0.csr_addr  = csr_addr_i;
                slot_d_p0.exception = exception_i;
                slot_d_p0.valid     = 1'b1;
                slot_d_p0.is_load   = (inst_i[6:0] == INST_TYPE_L);
                slot_d_p0.rd        = inst_i[11:7];
            end
        endcase
    end

    // Stage p1: execute-side slot register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            slot_p1 <= bubble_slot();
        end else begin
            slot_p1 <= slot_d_p0;
        end
    end

    assign inst_o             = slot_p1.inst;
    assign inst_addr_o        = slot_p1.inst_addr;
    assign op1_o              = slot_p1.op1;
    assign op2_o              = slot_p1.op2;
    assign reg_we_o           = slot_p1.reg_we;
    assign reg_waddr_o        = slot_p1.reg_waddr;
    assign csr_we_o           = slot_p1.csr_we;
    assign csr_addr_o         = slot_p1.csr_addr;
    assign exception_o        = slot_p1.exception;
    assign valid_o            = slot_p1.valid;
    assign pre_inst_is_load_o = slot_p1.is_load;
    assign exe_rd_o           = slot_p1.rd;

    sat_cnt16 u_bubble_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (action_p0 == ACT_BUBBLE),
        .cnt_o   (bubble_cnt_o)
    );

    sat_cnt16 u_flush_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (action_p0 == ACT_FLUSH),
        .cnt_o   (flush_cnt_o)
    );

endmodule

// File: doc/id_exe.md
ID_EXE -- requirements
Module: id_exe

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk_i in 1 rising-edge clock; rst_n_i in 1 asynchronous active-low reset.
REQ-002 The block SHALL have these decode-side inputs:
- inst_i in 32: decoded instruction.
- inst_addr_i in 32: instruction PC.
- op1_i, op2_i in 32 each: forwarded operands.
- reg_we_i in 1, reg_waddr_i in 5: GPR write enable and address.
- csr_we_i in 1, csr_addr_i in 12: CSR write enable and address.
- exception_i in 32: exception flags (bit1 ecall, bit0 mret).
REQ-003 The block SHALL have these control inputs from ctrl:
- flush_i in 1: squash the slot.
- stall_exe_i in 1: hold the slot.
- stall_id_i in 1: decode stalled.
REQ-004 The block SHALL have these execute-side outputs:
- inst_o, inst_addr_o, op1_o, op2_o out 32 each.
- reg_we_o out 1, reg_waddr_o out 5.
- csr_we_o out 1, csr_addr_o out 12.
- exception_o out 32.
- valid_o out 1: slot holds a real instruction.
REQ-005 The block SHALL have these hazard outputs to decode:
- pre_inst_is_load_o out 1: the held instruction is a valid load.
- exe_rd_o out 5: rd of the held instruction.
REQ-006 The block SHALL have these statistics outputs:
- bubble_cnt_o out 16: load-use bubbles inserted.
- flush_cnt_o out 16: flushes taken.

Function
REQ-007 All outputs SHALL be registered, with a latency of one cycle from decode inputs to execute outputs.
REQ-008 The per-edge action SHALL follow this priority: flush_i, then stall_exe_i, then stall_id_i, then load.
REQ-009 A flush SHALL load a bubble regardless of the stall inputs.
REQ-010 Hold (stall_exe_i=1, flush_i=0) SHALL keep every output unchanged, including valid_o and the hazard outputs.
REQ-011 Bubble (stall_id_i=1, stall_exe_i=0, flush_i=0) SHALL load a bubble so the ID instruction is not duplicated into EXE.
REQ-012 Load (all three control inputs 0) SHALL capture all decode inputs and set valid_o=1.
REQ-013 A bubble SHALL mean:
- inst_o=32'h00000013 (NOP).
- inst_addr_o, op1_o, op2_o, exception_o, csr_addr_o, reg_waddr_o all 0.
- reg_we_o=0, csr_we_o=0, valid_o=0.
REQ-014 When a load cycle captures opcode 7'b0000011, pre_inst_is_load_o SHALL be 1; it SHALL be 0 after a bubble, flush or reset.
REQ-015 exe_rd_o SHALL equal the captured inst_i[11:7] on a load, be 0 on a bubble, and track the held slot otherwise.
REQ-016 bubble_cnt_o SHALL increment by 1 on each Bubble action and saturate at 16'hFFFF.
REQ-017 flush_cnt_o SHALL increment by 1 on each flush edge and saturate at 16'hFFFF.
REQ-018 The counters SHALL not change on hold or load cycles.
REQ-019 A flush asserted together with stall_exe_i SHALL count only in flush_cnt_o.
REQ-020 A slot carrying reg_waddr_i=0 with reg_we_i=1 SHALL be passed through unchanged; x0 suppression belongs to the consumer.

Reset
REQ-021 While rst_n_i=0, all outputs SHALL equal the bubble values, including inst_o=NOP; both counters and pre_inst_is_load_o SHALL be 0.
REQ-022 Assertion of rst_n_i SHALL take effect asynchronously, mid-hold or mid-stall, without waiting for clk_i.
REQ-023 Deassertion SHALL be synchronised upstream; the first edge after deassertion SHALL perform a normal priority evaluation.

Structure
REQ-024 NOP, INST_TYPE_L (7'b0000011), ZERO, ZERO_REG, WRITE_ENABLE/WRITE_DISABLE and the widths DATA_WIDTH, ADDR_WIDTH, RADDR_WIDTH, CSR_ADDR_WIDTH SHALL come from the shared defines.v.
REQ-025 The bubble/flush counter SHALL be one sub-module, sat_cnt16 (inputs: clk_i, rst_n_i, inc_i; output: cnt_o), instantiated twice.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Load: inst_i=32'h00500093, op1_i=5, reg_we_i=1, reg_waddr_i=1 -> next edge: inst_o=32'h00500093, valid_o=1, exe_rd_o=1, pre_inst_is_load_o=0.
- Load-use: load lw x3,0(x2) (32'h00012183), then stall_id_i=1 for one cycle -> first edge pre_inst_is_load_o=1 and exe_rd_o=3; second edge inst_o=NOP, valid_o=0, bubble_cnt_o=1.
- Flush over hold: slot holds a valid instruction; flush_i=1 with stall_exe_i=1 -> inst_o=NOP, reg_we_o=0, flush_cnt_o=1, bubble_cnt_o unchanged.
- Hold: stall_exe_i=1 for 3 cycles while inputs change -> all outputs equal the pre-hold values throughout.
- Saturation: preload counters by forcing 65535 bubbles, then one more bubble -> bubble_cnt_o=16'hFFFF.
- Async reset: rst_n_i pulsed low between edges during a hold -> outputs reach bubble values before the next edge and counters read 0.
